// File: rtl/ph_fifo_n.sv
// Parasite-to-host show-ahead FIFO with latch/burst presentation, occupancy count and sticky error flags.
// Latency: data visible on h_data one edge after the write; status follows registered state one edge after a strobe.
// Backpressure: p_full stalls the parasite (drop and flag on violation); h_data_available gates the host.
module ph_fifo_n #(
    parameter int              WIDTH       = 8,
    parameter int              DEPTH       = 2,
    parameter int              BURST       = DEPTH,
    parameter int              RESET_PRIME = 1,
    parameter logic [WIDTH-1:0] RESET_DATA = WIDTH'(8'hAA)
) (
    input  logic                       phi2,
    input  logic                       rst,
    input  logic                       one_byte_mode,
    input  logic                       p_we,
    input  logic [WIDTH-1:0]           p_data,
    output logic                       p_full,
    output logic                       p_overflow,
    input  logic                       h_re,
    output logic [WIDTH-1:0]           h_data,
    output logic                       h_data_available,
    output logic                       h_zero_bytes_available,
    output logic                       h_underflow,
    output logic [$clog2(DEPTH+1)-1:0] h_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} phase_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    cnt_n;
    phase_t           phase;
    logic             mode_q;
    logic             wr_acc;
    logic             rd_acc;
    logic             cnt_nz;

    assign cnt_nz = (count != '0);

    assign p_full                 = one_byte_mode ? cnt_nz : (phase == DRAIN);
    assign h_data_available       = one_byte_mode ? cnt_nz : (phase == DRAIN);
    assign h_zero_bytes_available = !cnt_nz;
    assign h_data                 = mem[rd_ptr];
    assign h_count                = count;

    assign rd_acc = h_re & cnt_nz;
    // A latch being emptied this cycle can take the new byte at the same edge.
    assign wr_acc = p_we & (!p_full | (one_byte_mode & rd_acc));

    always_comb begin
        cnt_n = count;
        if (wr_acc && !rd_acc)
            cnt_n = count + 1'b1;
        else if (rd_acc && !wr_acc)
            cnt_n = count - 1'b1;
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= RESET_DATA;
            wr_ptr      <= AW'(RESET_PRIME);
            rd_ptr      <= '0;
            count       <= CW'(RESET_PRIME);
            phase       <= (RESET_PRIME != 0) ? DRAIN : FILL;
            mode_q      <= one_byte_mode;
            p_overflow  <= 1'b0;
            h_underflow <= 1'b0;
        end else begin
            mode_q <= one_byte_mode;
            if (wr_acc) begin
                mem[wr_ptr] <= p_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            count <= cnt_n;
            if (p_we && !wr_acc)
                p_overflow <= 1'b1;
            if (h_re && !cnt_nz)
                h_underflow <= 1'b1;
            // Leaving latch mode re-derives the phase from occupancy.
            if (mode_q && !one_byte_mode)
                phase <= (cnt_n >= CW'(BURST)) ? DRAIN : FILL;
            else if (phase == FILL && cnt_n >= CW'(BURST))
                phase <= DRAIN;
            else if (phase == DRAIN && cnt_n == '0)
                phase <= FILL;
        end
    end

endmodule
